// File: rtl/imem_loader.sv
// Byte-serial program loader: packs low/high byte pairs into instruction words,
// writes them to instruction memory from address 0, then pulses start to the core.
//
// state | meaning
// IDLE  | no session; waiting for load_en
// LO    | waiting for the low byte of the next instruction
// HI    | low byte held; waiting for the high byte, which issues the write
// GO    | load finished cleanly; start pulse is on the output this cycle
module imem_loader #(
   parameter int instr_width = 9,
   parameter int addr_width  = 9,
   parameter int byte_width  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic                    in_valid,
   input  logic [byte_width-1:0]   in_data,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic                    wr_en,
   output logic [addr_width-1:0]   wr_addr,
   output logic [instr_width-1:0]  wr_data,
   output logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [addr_width:0]     word_count
);

   localparam int hi_bits = instr_width - byte_width;

   typedef enum logic [1:0] {IDLE, LO, HI, GO} state_t;

   state_t                  state, state_nx;
   logic [byte_width-1:0]   lo_q;
   logic [addr_width-1:0]   addr_q;
   logic                    xfer;
   logic                    wr_xfer;
   logic                    addr_full;
   logic                    err_nx;

   // in_ready comes from state alone so it never loops back through in_valid
   assign in_ready  = (state == LO) || (state == HI);
   assign xfer      = in_valid && in_ready;
   assign wr_xfer   = xfer && (state == HI);
   assign addr_full = &addr_q;

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (load_en) state_nx = LO;
         end
         LO: begin
            if (load_en) begin
               state_nx = LO;
            end else if (xfer) begin
               if (in_last) begin
                  state_nx = IDLE;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = HI;
               end
            end
         end
         HI: begin
            if (load_en) begin
               state_nx = LO;
            end else if (xfer) begin
               if (in_last) begin
                  state_nx = GO;
               end else if (addr_full) begin
                  state_nx = IDLE;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = LO;
               end
            end
         end
         GO: begin
            state_nx = load_en ? LO : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lo_q       <= '0;
         addr_q     <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         wr_en <= 1'b0;
         start <= 1'b0;
         if (xfer && (state == LO)) lo_q <= in_data;
         // a high-byte transfer coinciding with a restart still reaches memory
         if (wr_xfer) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_q;
            wr_data <= {in_data[hi_bits-1:0], lo_q};
         end
         if (load_en) begin
            addr_q     <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
         end else begin
            if (wr_xfer) begin
               addr_q     <= addr_q + 1'b1;
               word_count <= word_count + 1'b1;
            end
            if (err_nx) error <= 1'b1;
            if (state_nx == GO) begin
               start <= 1'b1;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from a
// byte-stream model that pairs bytes into words and applies the end/overflow rules.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_en;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [8:0] wr_data;
   logic       start;
   logic       busy;
   logic       done;
   logic       error;
   logic [9:0] word_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] stream [0:1099];
   int         mon_addr[$];
   int         mon_data[$];
   int         mon_cyc[$];
   int         hi_cyc[$];
   int         start_cnt;
   int         start_cyc;
   int         last_cyc;

   imem_loader dut (
      .clk(clk), .reset(reset), .load_en(load_en), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
      .busy(busy), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         mon_addr.push_back(int'(wr_addr));
         mon_data.push_back(int'(wr_data));
         mon_cyc.push_back(cyc);
      end
      if (start) begin
         start_cnt++;
         start_cyc = cyc;
      end
   end

   // Expected outcome of a stream: bytes pair up low-first, the stream closes at the
   // byte flagged last, and at most 512 words fit before overflow aborts the load.
   task automatic model(input int len, input int last_idx, output int words, output bit exp_done);
      int n;
      n        = (last_idx >= 0) ? last_idx + 1 : len;
      words    = (n / 2 > 512) ? 512 : n / 2;
      exp_done = (last_idx >= 0) && (n % 2 == 0) && (n / 2 <= 512);
   endtask

   task automatic pulse_load();
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic drive_stream(input int len, input int last_idx, input int gap_pct);
      int   i = 0;
      int   guard = 0;
      logic rdy;
      logic xf;
      hi_cyc.delete();
      while (i < len && guard < 20000) begin
         if (!busy) break;
         in_data  = stream[i];
         in_last  = (i == last_idx);
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         #1 rdy = in_ready;
         in_valid = ~in_valid;
         #1;
         checks++;
         if (in_ready !== rdy) begin
            errors++;
            $display("FAIL in_ready_indep: in_ready=%b after in_valid flip, was %b", in_ready, rdy);
         end
         in_valid = ~in_valid;
         xf = in_valid && rdy;
         @(negedge clk);
         guard++;
         if (xf) begin
            if (i % 2 == 1) hi_cyc.push_back(cyc);
            if (i == last_idx) begin
               last_cyc = cyc;
               i = len;
            end else begin
               i++;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (guard >= 20000) begin
         errors++;
         $display("FAIL stream_timeout: sent %0d of %0d bytes, required all", i, len);
      end
   endtask

   task automatic run_session(input string name, input int len, input int last_idx, input int gap_pct);
      int       words;
      bit       exp_done;
      logic [8:0] e;
      mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
      start_cnt = 0;
      pulse_load();
      checks++;
      if ({busy, in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL %s load_resp: busy,in_ready=%b required 11", name, {busy, in_ready});
      end
      drive_stream(len, last_idx, gap_pct);
      repeat (4) @(negedge clk);
      model(len, last_idx, words, exp_done);
      checks++;
      if (mon_addr.size() != words) begin
         errors++;
         $display("FAIL %s write_count: got %0d required %0d", name, mon_addr.size(), words);
      end
      for (int w = 0; w < words && w < mon_addr.size(); w++) begin
         e = {stream[2*w+1][0], stream[2*w]};
         checks++;
         if (mon_addr[w] != w || mon_data[w] != int'(e)) begin
            errors++;
            $display("FAIL %s write[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                     name, w, mon_addr[w], mon_data[w], w, e);
         end
         checks++;
         if (w < hi_cyc.size() && mon_cyc[w] != hi_cyc[w]) begin
            errors++;
            $display("FAIL %s write_cycle[%0d]: got %0d required %0d", name, w, mon_cyc[w], hi_cyc[w]);
         end
         if (gap_pct == 0 && w > 0) begin
            checks++;
            if (mon_cyc[w] - mon_cyc[w-1] != 2) begin
               errors++;
               $display("FAIL %s throughput[%0d]: spacing %0d required 2", name, w, mon_cyc[w] - mon_cyc[w-1]);
            end
         end
      end
      checks++;
      if (start_cnt != (exp_done ? 1 : 0)) begin
         errors++;
         $display("FAIL %s start_count: got %0d required %0d", name, start_cnt, exp_done ? 1 : 0);
      end
      if (exp_done) begin
         checks++;
         if (start_cyc != last_cyc) begin
            errors++;
            $display("FAIL %s start_cycle: got %0d required %0d", name, start_cyc, last_cyc);
         end
      end
      checks++;
      if ({done, error, busy} !== {exp_done, !exp_done, 1'b0}) begin
         errors++;
         $display("FAIL %s flags: done,error,busy=%b required %b", name, {done, error, busy},
                  {exp_done, !exp_done, 1'b0});
      end
      checks++;
      if (word_count !== 10'(words)) begin
         errors++;
         $display("FAIL %s word_count: got %0d required %0d", name, word_count, words);
      end
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) stream[k] = 8'($urandom);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, start, busy, done, error, word_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {in_ready, wr_en, wr_addr, wr_data, start, busy, done, error, word_count});
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: in_ready,busy=%b required 00", {in_ready, busy});
      end
   endtask

   task automatic test_clean_load();
      logic [7:0] b [0:5];
      b = '{8'h34, 8'h01, 8'hFF, 8'h00, 8'h07, 8'h03};
      for (int k = 0; k < 6; k++) stream[k] = b[k];
      run_session("clean", 6, 5, 0);
      checks++;
      if (mon_data.size() == 3 && (mon_data[0] != 'h134 || mon_data[1] != 'h0FF || mon_data[2] != 'h107)) begin
         errors++;
         $display("FAIL clean_values: got %h %h %h required 134 0ff 107", mon_data[0], mon_data[1], mon_data[2]);
      end
   endtask

   task automatic test_backpressure();
      int n;
      run_session("clean_gaps", 6, 5, 40);
      for (int r = 0; r < 5; r++) begin
         n = 2 * $urandom_range(1, 20);
         fill_random(n);
         run_session("random_gaps", n, n - 1, $urandom_range(20, 60));
      end
   endtask

   task automatic test_odd();
      fill_random(3);
      run_session("odd", 3, 2, 0);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mon_addr.size() != 1 || word_count !== 10'd1) begin
         errors++;
         $display("FAIL idle_ignore: writes=%0d word_count=%0d required 1 and 1", mon_addr.size(), word_count);
      end
   endtask

   task automatic test_overflow();
      fill_random(1026);
      run_session("overflow", 1026, -1, 0);
      fill_random(1024);
      run_session("full_last", 1024, 1023, 0);
   endtask

   task automatic test_abort();
      int s0;
      fill_random(4);
      start_cnt = 0;
      pulse_load();
      drive_stream(4, -1, 0);
      @(negedge clk);
      checks++;
      if (word_count !== 10'd2) begin
         errors++;
         $display("FAIL abort_pre: word_count=%0d required 2", word_count);
      end
      pulse_load();
      checks++;
      if (word_count !== 10'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_clear: word_count=%0d busy=%b required 0 and 1", word_count, busy);
      end
      s0 = start_cnt;
      mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
      fill_random(4);
      drive_stream(4, 3, 30);
      repeat (4) @(negedge clk);
      checks++;
      if (mon_addr.size() != 2 || mon_addr[0] != 0 || mon_data[0] != int'({stream[1][0], stream[0]})) begin
         errors++;
         $display("FAIL abort_restart: writes=%0d first_addr=%0d required 2 writes from addr 0",
                  mon_addr.size(), mon_addr.size() > 0 ? mon_addr[0] : -1);
      end
      checks++;
      if (s0 != 0 || start_cnt != 1 || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_start: starts before=%0d total=%0d done=%b required 0, 1, 1", s0, start_cnt, done);
      end
   endtask

   task automatic test_reset_mid();
      fill_random(3);
      pulse_load();
      drive_stream(3, -1, 0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, start, busy, done, error, word_count} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got %b required all zero",
                  {in_ready, wr_en, wr_addr, wr_data, start, busy, done, error, word_count});
      end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, busy, wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_idle: in_ready,busy,wr_en=%b required 000", {in_ready, busy, wr_en});
      end
      pulse_load();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_reload: in_ready=%b required 1", in_ready);
      end
   endtask

   initial begin
      reset    = 1'b1;
      load_en  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean_load();
      test_backpressure();
      test_odd();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that writes 9-bit instruction words into instruction memory and then releases the core. It is the writer for the fetch unit's read side. It sits between the bench/host byte stream and the instruction-memory write port. When a load completes, it pulses the core's `start` so execution begins at address 0.

## Interface
Parameters:
- `instr_width`, 9, instruction word width
- `addr_width`, 9, instruction-memory address width (capacity 2**addr_width words)
- `byte_width`, 8, input stream width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `load_en`  in  1  one-cycle pulse; opens (or restarts) a load session
- `in_valid`  in  1  input byte valid
- `in_data`  in  `byte_width`  input byte
- `in_last`  in  1  qualifies `in_data` as the final byte of the stream
- `in_ready`  out  1  loader can accept a byte this cycle
- `wr_en`  out  1  instruction-memory write strobe
- `wr_addr`  out  `addr_width`  write address
- `wr_data`  out  `instr_width`  write data
- `start`  out  1  one-cycle pulse to the core after a clean load
- `busy`  out  1  session in progress
- `done`  out  1  sticky; last load completed cleanly
- `error`  out  1  sticky; last load aborted
- `word_count`  out  `addr_width+1`  words written in the current/last session

## Operation
- Handshake: a byte transfers on a rising edge where `in_valid && in_ready`. Data and `in_last` are sampled only on a transfer.
- Packing: two bytes per instruction, low byte first.
  - `wr_data = {hi[0], lo[7:0]}`.
  - `hi[7:1]` is ignored.
- FSM states: IDLE, LO, HI, GO.
  - IDLE: `in_ready=0`. `load_en` → LO. This clears the address, `word_count`, `done` and `error`.
  - LO: `in_ready=1`. A transfer latches `lo` → HI. If `in_last=1` on this transfer (odd byte count): set `error` → IDLE, with no write.
  - HI: `in_ready=1`. A transfer registers a write.
    - If `in_last=1` → GO.
    - Else, if the address just written was 2**addr_width−1 (memory full) → set `error` → IDLE.
    - Else → LO.
  - GO: `in_ready=0`. `start=1` for exactly this cycle, `done` is set, then → IDLE.
- Address: starts at 0 and increments by 1 after each write. It never wraps. Overflow is an error, per the HI rule.
- `word_count` increments with each `wr_en`. It holds after the session ends until the next `load_en`.
- `busy=1` in LO, HI and GO.
- `load_en` in any non-IDLE state aborts and restarts the session at LO.
  - Flags and counters clear.
  - A write already registered from the same edge still completes.
  - No `start` is issued for the aborted session.
- `in_valid` in IDLE or GO is ignored; no byte is consumed.

## Timing
- Reset (async assert): state IDLE. All outputs are 0: `in_ready`, `wr_en`, `wr_addr`, `wr_data`, `start`, `busy`, `done`, `error`, `word_count`.
- All outputs are registered, except `in_ready`, which is decoded from state only (no combinational path from `in_valid`).
- `load_en` at edge N → `busy=1` and `in_ready=1` in cycle N+1.
- High-byte transfer at edge N → `wr_en=1` with valid `wr_addr`/`wr_data` for exactly cycle N+1. `word_count` updates at N+1.
- Final transfer at edge N → `start=1` and `done=1` at N+1. `busy=0` and `start=0` at N+2.
- Error at edge N → `error=1` and `busy=0` at N+1. No `start`.
- Sustained throughput: 1 byte/cycle, i.e. one instruction per 2 cycles.
- Reset deasserted mid-session: the loader is in IDLE. Memory contents already written are not touched.

## Test plan
- Clean load: `load_en`, then bytes 0x34,0x01, 0xFF,0x00, 0x07,0x03 (`in_last` on the last byte) → writes (0,0x134), (1,0x0FF), (2,0x107). `start` for one cycle, `done=1`, `word_count=3`.
- Back-pressure and gaps: randomly drop `in_valid` during the clean-load stream → identical writes and cycle order. No byte is lost or duplicated. `in_ready` never depends on `in_valid`.
- Odd stream: 3 bytes with `in_last` on byte 3 → exactly 1 write, `error=1`, `done=0`, no `start`, `word_count=1`.
- Overflow: 1026 bytes, no `in_last` → 512 writes to addresses 0..511, then `error=1` and no further writes. With `in_last` on byte 1024 instead → `done=1`, `start` pulses, `word_count=512`.
- Abort: `load_en` again after 2 words → `word_count` returns to 0. The next write lands at address 0. Only the restarted session produces `start`.
- Async reset while in HI: `reset` asserted between edges → all outputs 0 immediately. `in_ready=0` until the next `load_en`.
